// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: default operand width,
// operation encodings and the control FSM state encoding.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  // op[1] selects divide, op[0] selects unsigned.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_SIGN = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to apply the sign correction to results.
// Ports:
//   din  - value to pass through or negate
//   neg  - 1: dout = -din, 0: dout = din
//   dout - result, same width as din
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Negate or pass through.
  always_comb begin
    dout = din;
    if (neg) begin
      dout = (~din) + ONE;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/mult_div_hilo.sv
// Iterative multiply/divide unit owning the HI and LO registers.
// Executes MULT, MULTU (radix-2 shift-add) and DIV, DIVU (restoring), one bit
// per cycle on operand magnitudes, followed by a single sign-correction cycle
// that writes HI/LO. MTHI/MTLO write opA directly when the unit is not busy.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   start, op           - one-cycle request and operation (mdu_pkg OP_*)
//   opA, opB            - rs (multiplicand/dividend), rt (multiplier/divisor)
//   mthi, mtlo          - move opA into HI / LO
//   hi, lo              - HI / LO registers
//   busy                - operation in flight
//   done                - one-cycle pulse when HI/LO hold a new result
//   divZero             - pulses with done for a divide by zero
module mult_div_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mdu_state_e          state_r, state_nxt_s;
  logic [CW-1:0]       cnt_r;
  logic [WIDTH-1:0]    mcand_r;
  logic [WIDTH-1:0]    dvsr_r;
  logic [2*WIDTH-1:0]  prod_r;
  logic [WIDTH:0]      rem_r;
  logic [WIDTH-1:0]    quo_r;
  logic                sign_a_r, sign_b_r, is_div_r;
  logic [WIDTH-1:0]    hi_r, lo_r;
  logic                busy_r, done_r, divzero_r;

  logic                is_signed_s, neg_a_s, neg_b_s;
  logic [WIDTH-1:0]    abs_a_s, abs_b_s;
  logic                idle_like_s, accept_s, div_zero_s, cnt_last_s;
  logic [WIDTH:0]      mul_sum_s;
  logic [2*WIDTH-1:0]  mul_nxt_s;
  logic [WIDTH:0]      div_shift_s, div_diff_s;
  logic                div_fits_s;
  logic [2*WIDTH-1:0]  prod_fix_s;
  logic [WIDTH-1:0]    quo_fix_s, rem_fix_s;

  assign is_signed_s = ~op[0];
  assign neg_a_s     = is_signed_s & opA[WIDTH-1];
  assign neg_b_s     = is_signed_s & opB[WIDTH-1];
  assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign accept_s    = start && idle_like_s;
  assign div_zero_s  = op[1] && (opB == {WIDTH{1'b0}});
  assign cnt_last_s  = (cnt_r == CNT_LAST);

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  mdu_abs_neg #(.W(WIDTH)) u_abs_a (.din(opA), .neg(neg_a_s), .dout(abs_a_s));
  mdu_abs_neg #(.W(WIDTH)) u_abs_b (.din(opB), .neg(neg_b_s), .dout(abs_b_s));

  // Result sign correction: product and quotient follow signA^signB, the
  // remainder follows the dividend. Unsigned ops latch both flags as 0.
  mdu_abs_neg #(.W(2*WIDTH)) u_fix_prod (
    .din(prod_r), .neg(sign_a_r ^ sign_b_r), .dout(prod_fix_s));
  mdu_abs_neg #(.W(WIDTH)) u_fix_quo (
    .din(quo_r), .neg(sign_a_r ^ sign_b_r), .dout(quo_fix_s));
  mdu_abs_neg #(.W(WIDTH)) u_fix_rem (
    .din(rem_r[WIDTH-1:0]), .neg(sign_a_r), .dout(rem_fix_s));

  // Shift-add step: the multiplier sits in the low half of the accumulator
  // and is consumed LSB first while the partial product grows from the top.
  assign mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                     (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
  assign mul_nxt_s = {mul_sum_s, prod_r[WIDTH-1:1]};

  // Restoring step: the extra remainder bit catches the borrow of the trial
  // subtraction; no borrow means the quotient bit is 1.
  assign div_shift_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, dvsr_r};
  assign div_fits_s  = ~div_diff_s[WIDTH];

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (!start) begin
          state_nxt_s = ST_IDLE;
        end else if (!op[1]) begin
          state_nxt_s = ST_MUL;
        end else if (div_zero_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end
      ST_MUL: begin
        if (cnt_last_s) begin
          state_nxt_s = ST_SIGN;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_DIV: begin
        if (cnt_last_s) begin
          state_nxt_s = ST_SIGN;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end
      ST_SIGN: state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered status outputs, decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
    end else begin
      busy_r    <= (state_nxt_s == ST_MUL) || (state_nxt_s == ST_DIV) ||
                   (state_nxt_s == ST_SIGN);
      done_r    <= (state_nxt_s == ST_DONE);
      divzero_r <= accept_s && div_zero_s;
    end
  end

  // Datapath: operand latch, iteration, result write and HI/LO moves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= {CW{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      dvsr_r   <= {WIDTH{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      rem_r    <= {(WIDTH+1){1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      is_div_r <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // A start on the same edge wins over mthi/mtlo.
            sign_a_r <= neg_a_s;
            sign_b_r <= neg_b_s;
            is_div_r <= op[1];
            mcand_r  <= abs_a_s;
            dvsr_r   <= abs_b_s;
            prod_r   <= {{WIDTH{1'b0}}, abs_b_s};
            quo_r    <= abs_a_s;
            rem_r    <= {(WIDTH+1){1'b0}};
            cnt_r    <= {CW{1'b0}};
          end else begin
            if (mthi) hi_r <= opA;
            if (mtlo) lo_r <= opA;
          end
        end
        ST_MUL: begin
          prod_r <= mul_nxt_s;
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        ST_DIV: begin
          rem_r <= div_fits_s ? div_diff_s : div_shift_s;
          quo_r <= {quo_r[WIDTH-2:0], div_fits_s};
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        ST_SIGN: begin
          if (is_div_r) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end else begin
            hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix_s[WIDTH-1:0];
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign hi      = hi_r;
  assign lo      = lo_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign divZero = divzero_r;

endmodule

// File: tb/tb_mult_div_hilo.sv
// Self-checking bench for mult_div_hilo: directed vectors plus randomized
// operations compared against an arithmetic reference model.
module tb_mult_div_hilo;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, mthi, mtlo;
  logic [1:0]    op;
  logic [W-1:0]  opA, opB;
  logic [W-1:0]  hi, lo;
  logic          busy, done, divZero;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] mdl_hi = 32'h0;
  logic [W-1:0] mdl_lo = 32'h0;

  mult_div_hilo #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .opA(opA), .opB(opB),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .divZero(divZero)
  );

  always #5 clk = ~clk;

  // Reference model from plain integer arithmetic (C-style truncating division).
  function automatic void model(input logic [1:0] o, input logic [31:0] a, b,
                                input logic [31:0] ph, pl,
                                output logic [31:0] eh, el, output logic edz);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edz = 1'b0; eh = ph; el = pl;
    case (o)
      2'b00: begin sp = sa * sb; {eh, el} = sp; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; {eh, el} = up; end
      2'b10: begin
        if (b == 32'd0) edz = 1'b1;
        else begin sq = sa / sb; sr = sa % sb; el = sq[31:0]; eh = sr[31:0]; end
      end
      default: begin
        if (b == 32'd0) edz = 1'b1;
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endfunction

  task automatic do_move(input logic [31:0] v, input logic h, input logic l);
    @(negedge clk);
    opA = v; mthi = h; mtlo = l; start = 1'b0;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (h) mdl_hi = v;
    if (l) mdl_lo = v;
  endtask

  // Issue one operation and wait (bounded) for done; lat counts edges after the start edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, b, output int lat,
                        output logic [31:0] rh, rl, output logic rdz);
    @(negedge clk);
    op = o; opA = a; opB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    if (!done) lat = -1;
    rh = hi; rl = lo; rdz = divZero;
  endtask

  task automatic test_reset();
    logic saw;
    reset_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; opA = 32'h0; opB = 32'h0;
    repeat (2) @(negedge clk);
    n_tests++; if ({hi, lo, busy, done, divZero} !== {64'h0, 3'b000}) begin
      n_fail++; $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b, want all 0", hi, lo, busy, done, divZero);
    end
    reset_n = 1'b1;
    do_move(32'hA5A5A5A5, 1'b1, 1'b1);
    n_tests++; if (hi !== 32'hA5A5A5A5 || lo !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL reset_preload: got hi=%h lo=%h, want a5a5a5a5", hi, lo);
    end
    @(negedge clk); op = 2'b01; opA = 32'h1234; opB = 32'h5678; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy_before: got busy=%b, want 1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if ({hi, lo, busy, done} !== {64'h0, 2'b00}) begin
      n_fail++; $display("FAIL reset_midop: got hi=%h lo=%h busy=%b done=%b, want 0", hi, lo, busy, done);
    end
    @(negedge clk); reset_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin @(negedge clk); if (done || busy) saw = 1'b1; end
    n_tests++; if (saw !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_no_done: got activity=%b hi=%h lo=%h, want 0", saw, hi, lo);
    end
    mdl_hi = 32'h0; mdl_lo = 32'h0;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
    logic [31:0] t_a  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000};
    logic [31:0] t_b  [5] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'hFFFFFFFF};
    logic [31:0] t_hi [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h0};
    logic [31:0] t_lo [5] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'h80000000};
    int lat; logic [31:0] rh, rl; logic rdz;
    for (int i = 0; i < 5; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], lat, rh, rl, rdz);
      n_tests++; if (lat !== LAT || rdz !== 1'b0) begin
        n_fail++; $display("FAIL directed_lat[%0d]: got lat=%0d dz=%b, want %0d 0", i, lat, rdz, LAT);
      end
      n_tests++; if (rh !== t_hi[i] || rl !== t_lo[i]) begin
        n_fail++; $display("FAIL directed_val[%0d]: got hi=%h lo=%h, want hi=%h lo=%h", i, rh, rl, t_hi[i], t_lo[i]);
      end
      @(negedge clk);
      n_tests++; if (done !== 1'b0) begin
        n_fail++; $display("FAIL directed_pulse[%0d]: got done=%b, want 0", i, done);
      end
      mdl_hi = t_hi[i]; mdl_lo = t_lo[i];
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] rh, rl; logic rdz;
    do_move(32'h11112222, 1'b1, 1'b0);
    do_move(32'h33334444, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      run_op((i == 0) ? 2'b10 : 2'b11, 32'd5 + 32'(i), 32'd0, lat, rh, rl, rdz);
      n_tests++; if (lat !== 0 || rdz !== 1'b1) begin
        n_fail++; $display("FAIL divzero_flag[%0d]: got lat=%0d dz=%b, want 0 1", i, lat, rdz);
      end
      n_tests++; if (rh !== 32'h11112222 || rl !== 32'h33334444) begin
        n_fail++; $display("FAIL divzero_keep[%0d]: got hi=%h lo=%h, want 11112222 33334444", i, rh, rl);
      end
      @(negedge clk);
      n_tests++; if (done !== 1'b0 || divZero !== 1'b0) begin
        n_fail++; $display("FAIL divzero_pulse[%0d]: got done=%b dz=%b, want 0 0", i, done, divZero);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat; logic [31:0] eh, el; logic edz;
    logic [31:0] a = $urandom, b = $urandom;
    @(negedge clk); op = 2'b01; opA = a; opB = b; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 0;
    repeat (4) begin @(negedge clk); lat++; end
    op = 2'b10; opA = 32'hDEADBEEF; opB = 32'd0; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk); lat++; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    n_tests++; if (busy !== 1'b1 || hi !== mdl_hi || lo !== mdl_lo || divZero !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignore_mid: got busy=%b hi=%h lo=%h dz=%b, want 1 %h %h 0", busy, hi, lo, divZero, mdl_hi, mdl_lo);
    end
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    model(2'b01, a, b, mdl_hi, mdl_lo, eh, el, edz);
    n_tests++; if (lat !== LAT || hi !== eh || lo !== el || divZero !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignore_res: got lat=%0d hi=%h lo=%h, want %0d %h %h", lat, hi, lo, LAT, eh, el);
    end
    mdl_hi = eh; mdl_lo = el;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rh, rl, eh, el; logic rdz, edz;
    logic [31:0] a1 = $urandom, b1 = $urandom, a2 = $urandom, b2 = $urandom | 32'd1;
    run_op(2'b00, a1, b1, lat, rh, rl, rdz);
    model(2'b00, a1, b1, mdl_hi, mdl_lo, eh, el, edz);
    n_tests++; if (lat !== LAT || rh !== eh || rl !== el) begin
      n_fail++; $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h, want %0d %h %h", lat, rh, rl, LAT, eh, el);
    end
    mdl_hi = eh; mdl_lo = el;
    op = 2'b10; opA = a2; opB = b2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: got done=%b busy=%b, want 0 1", done, busy);
    end
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    model(2'b10, a2, b2, mdl_hi, mdl_lo, eh, el, edz);
    n_tests++; if (lat !== LAT || hi !== eh || lo !== el || divZero !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h, want %0d %h %h", lat, hi, lo, LAT, eh, el);
    end
    mdl_hi = eh; mdl_lo = el;
  endtask

  task automatic test_move();
    int lat; logic [31:0] eh, el; logic edz;
    do_move(32'h12345678, 1'b1, 1'b1);
    n_tests++; if (hi !== 32'h12345678 || lo !== 32'h12345678) begin
      n_fail++; $display("FAIL move_both: got hi=%h lo=%h, want 12345678", hi, lo);
    end
    do_move(32'hCAFEF00D, 1'b1, 1'b1);
    @(negedge clk); op = 2'b01; opA = 32'h12345678; opB = 32'd3;
    start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk); start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    n_tests++; if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D || busy !== 1'b1) begin
      n_fail++; $display("FAIL move_dropped: got hi=%h lo=%h busy=%b, want cafef00d cafef00d 1", hi, lo, busy);
    end
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    model(2'b01, 32'h12345678, 32'd3, mdl_hi, mdl_lo, eh, el, edz);
    n_tests++; if (lat !== LAT || hi !== eh || lo !== el) begin
      n_fail++; $display("FAIL move_start_res: got lat=%0d hi=%h lo=%h, want %0d %h %h", lat, hi, lo, LAT, eh, el);
    end
    mdl_hi = eh; mdl_lo = el;
  endtask

  task automatic test_random();
    int lat, sel; logic [1:0] o; logic [31:0] a, b, rh, rl, eh, el; logic rdz, edz;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      a = $urandom; b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) begin a = 32'($signed(8'($urandom))); b = 32'($signed(4'($urandom))) | 32'd1; end
      if ($urandom_range(0, 3) == 0) do_move($urandom, 1'($urandom), 1'($urandom));
      run_op(o, a, b, lat, rh, rl, rdz);
      model(o, a, b, mdl_hi, mdl_lo, eh, el, edz);
      n_tests++; if (lat !== (edz ? 0 : LAT) || rdz !== edz || rh !== eh || rl !== el) begin
        n_fail++; $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d dz=%b hi=%h lo=%h, want lat=%0d dz=%b hi=%h lo=%h",
                           i, o, a, b, lat, rdz, rh, rl, edz ? 0 : LAT, edz, eh, el);
      end
      mdl_hi = eh; mdl_lo = el;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_move();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
